// File: rtl/led_blinker_bank.sv
// rtl/led_blinker_bank.sv - multi-channel LED blinker/one-shot driver with reset and input synchronisers
module led_blinker_bank #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 27,
    parameter int SYNC_STAGES  = 2,
    parameter int DEFAULT_HALF = 16000000
) (
    input  logic                                        pixel_clk,
    input  logic                                        sys_rst,
    input  logic [2*N_CH-1:0]                           mode_i,
    input  logic [N_CH-1:0]                             trig_i,
    input  logic                                        cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_half,
    output logic [N_CH-1:0]                             led_o,
    output logic [N_CH-1:0]                             tick_o,
    output logic                                        rst_sync_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_ONESHOT = 2'b11
    } mode_e;

    logic [SYNC_STAGES-1:0] rst_ff_q;
    logic                   rst_sync;

    logic [2*N_CH-1:0] mode_sync_q [SYNC_STAGES];
    logic [N_CH-1:0]   trig_sync_q [SYNC_STAGES];
    logic [N_CH-1:0]   trig_last_q;
    logic [2*N_CH-1:0] mode_s;
    logic [N_CH-1:0]   trig_edge;

    mode_e             prev_mode_q [N_CH];
    logic [CNT_W-1:0]  half_q      [N_CH];
    logic [CNT_W-1:0]  cnt_q       [N_CH];
    logic [CNT_W-1:0]  cnt_d       [N_CH];
    logic [N_CH-1:0]   led_q, led_d;
    logic [N_CH-1:0]   tick_q, tick_d;

    mode_e             cur_mode;
    logic [CNT_W-1:0]  eff_m1;
    logic              expired;

    // Set asynchronously, released through SYNC_STAGES flops so deassertion is clean.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rst_ff_q <= '1;
        end else begin
            rst_ff_q <= {rst_ff_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync   = rst_ff_q[SYNC_STAGES-1];
    assign rst_sync_o = rst_sync;

    always_ff @(posedge pixel_clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                mode_sync_q[i] <= '0;
                trig_sync_q[i] <= '0;
            end
            trig_last_q <= '0;
        end else begin
            mode_sync_q[0] <= mode_i;
            trig_sync_q[0] <= trig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mode_sync_q[i] <= mode_sync_q[i-1];
                trig_sync_q[i] <= trig_sync_q[i-1];
            end
            trig_last_q <= trig_sync_q[SYNC_STAGES-1];
        end
    end

    assign mode_s    = mode_sync_q[SYNC_STAGES-1];
    assign trig_edge = trig_sync_q[SYNC_STAGES-1] & ~trig_last_q;

    always_ff @(posedge pixel_clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < N_CH; i++) begin
                half_q[i] <= HALF_RST;
            end
        end else if (cfg_we && ({1'b0, cfg_ch} < N_CH_L)) begin
            half_q[cfg_ch] <= cfg_half;
        end
    end

    // Priority per channel: mode change, then trigger, then counter expiry.
    always_comb begin
        led_d    = led_q;
        tick_d   = '0;
        cur_mode = M_OFF;
        eff_m1   = '0;
        expired  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            cur_mode = mode_e'(mode_s[2*c +: 2]);
            eff_m1   = (half_q[c] == '0) ? '0 : half_q[c] - 1'b1;
            expired  = (cnt_q[c] >= eff_m1);
            if (cur_mode != prev_mode_q[c]) begin
                cnt_d[c] = '0;
                led_d[c] = (cur_mode == M_ON);
            end else begin
                case (cur_mode)
                    M_BLINK: begin
                        if (expired) begin
                            cnt_d[c]  = '0;
                            led_d[c]  = ~led_q[c];
                            tick_d[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                    M_ONESHOT: begin
                        if (trig_edge[c]) begin
                            cnt_d[c] = '0;
                            led_d[c] = 1'b1;
                        end else if (!led_q[c]) begin
                            cnt_d[c] = '0;
                        end else if (expired) begin
                            cnt_d[c]  = '0;
                            led_d[c]  = 1'b0;
                            tick_d[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                    default: cnt_d[c] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]       <= '0;
                prev_mode_q[i] <= M_OFF;
            end
            led_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]       <= cnt_d[i];
                prev_mode_q[i] <= mode_e'(mode_s[2*i +: 2]);
            end
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_blinker_bank.sv
// tb/tb_led_blinker_bank.sv - scoreboard bench for led_blinker_bank against a timestamp-based model
module tb_led_blinker_bank;

    localparam int N_CH         = 4;
    localparam int CNT_W        = 8;
    localparam int SYNC_STAGES  = 2;
    localparam int DEFAULT_HALF = 4;

    logic             pixel_clk = 1'b0;
    logic             sys_rst   = 1'b0;
    logic [7:0]       mode_i    = '0;
    logic [3:0]       trig_i    = '0;
    logic             cfg_we    = 1'b0;
    logic [1:0]       cfg_ch    = '0;
    logic [7:0]       cfg_half  = '0;
    logic [3:0]       led_o;
    logic [3:0]       tick_o;
    logic             rst_sync_o;

    int checks = 0;
    int errors = 0;

    led_blinker_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .DEFAULT_HALF(DEFAULT_HALF)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .mode_i    (mode_i),
        .trig_i    (trig_i),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .led_o     (led_o),
        .tick_o    (tick_o),
        .rst_sync_o(rst_sync_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] tick;
        logic       rst;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs sampled at edge k act at edge k+2; each channel remembers the
    // edge number of its last event and fires once eff edges have elapsed.
    int         m_rst_cnt = 2;
    int         cyc_n     = 0;
    logic [3:0] m_led     = '0;
    int         m_half [4];
    int         m_prev [4];
    int         m_last [4];
    logic [7:0] mh [2];
    logic [3:0] th [3];

    always @(posedge pixel_clk) begin
        exp_t       e;
        logic [3:0] tk;
        int         md, eff;
        bit         te;
        cyc_n++;
        tk = '0;
        if (sys_rst) m_rst_cnt = 2;
        if (m_rst_cnt > 0) begin
            m_led = '0;
            for (int c = 0; c < 4; c++) begin
                m_half[c] = DEFAULT_HALF;
                m_prev[c] = 0;
                m_last[c] = cyc_n;
            end
            mh[0] = '0; mh[1] = '0;
            th[0] = '0; th[1] = '0; th[2] = '0;
            if (!sys_rst) m_rst_cnt--;
        end else begin
            for (int c = 0; c < 4; c++) begin
                md  = int'(mh[1][2*c +: 2]);
                te  = th[1][c] & ~th[2][c];
                eff = (m_half[c] == 0) ? 1 : m_half[c];
                if (md != m_prev[c]) begin
                    m_led[c]  = (md == 1);
                    m_last[c] = cyc_n;
                end else if (md == 2) begin
                    if (cyc_n - m_last[c] >= eff) begin
                        m_led[c]  = ~m_led[c];
                        tk[c]     = 1'b1;
                        m_last[c] = cyc_n;
                    end
                end else if (md == 3) begin
                    if (te) begin
                        m_led[c]  = 1'b1;
                        m_last[c] = cyc_n;
                    end else if (!m_led[c]) begin
                        m_last[c] = cyc_n;
                    end else if (cyc_n - m_last[c] >= eff) begin
                        m_led[c]  = 1'b0;
                        tk[c]     = 1'b1;
                        m_last[c] = cyc_n;
                    end
                end else begin
                    m_last[c] = cyc_n;
                end
                m_prev[c] = md;
            end
            if (cfg_we) m_half[cfg_ch] = int'(cfg_half);
            mh[1] = mh[0]; mh[0] = mode_i;
            th[2] = th[1]; th[1] = th[0]; th[0] = trig_i;
        end
        e.led  = m_led;
        e.tick = tk;
        e.rst  = (m_rst_cnt > 0);
        exp_q.push_back(e);
    end

    always @(negedge pixel_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rst_sync_o", 32'(rst_sync_o), 32'(e.rst));
            chk("led_o", 32'(led_o), 32'(e.led));
            chk("tick_o", 32'(tick_o), 32'(e.tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode_i[2*ch +: 2] = m;
    endtask

    task automatic write_half(input int ch, input int val);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_half = 8'(val);
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        #1 sys_rst = 1'b1;
        cyc(3);
        sys_rst = 1'b0;
        cyc(4);

        set_mode(0, 2'b10);
        cyc(90);

        write_half(3, 0);
        set_mode(3, 2'b10);
        cyc(10);

        write_half(1, 10);
        set_mode(1, 2'b10);
        cyc(9);
        write_half(1, 3);
        cyc(20);

        write_half(2, 5);
        set_mode(2, 2'b11);
        cyc(4);
        trig_i[2] = 1'b1; cyc(3); trig_i[2] = 1'b0;
        cyc(12);
        trig_i[2] = 1'b1; cyc(1); trig_i[2] = 1'b0;
        cyc(5);
        trig_i[2] = 1'b1; cyc(1); trig_i[2] = 1'b0;
        cyc(15);

        set_mode(0, 2'b01);
        cyc(10);
        set_mode(0, 2'b00);
        cyc(10);

        set_mode(0, 2'b10);
        cyc(7);
        #1 sys_rst = 1'b1;
        #1;
        chk("async rst_sync_o", 32'(rst_sync_o), 32'd1);
        chk("async led_o", 32'(led_o), 32'd0);
        chk("async tick_o", 32'(tick_o), 32'd0);
        cyc(2);
        sys_rst = 1'b0;
        cyc(30);

        repeat (1500) begin
            if ($urandom_range(15) == 0) set_mode(int'($urandom_range(3)), 2'($urandom_range(3)));
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(3) == 0) trig_i[c] = ~trig_i[c];
            end
            if ($urandom_range(7) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = 2'($urandom_range(3));
                cfg_half = 8'($urandom_range(7));
            end else begin
                cfg_we = 1'b0;
            end
            cyc(1);
        end
        cfg_we = 1'b0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
